// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface rr_priority_arbiter_if #(
    parameter int N = 8
);
    localparam int IDXW = $clog2(N);

    logic [N-1:0]    req;
    logic            rr_mode;
    logic            gnt_valid;
    logic            gnt_ready;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;

    modport slave (
        input  req,
        input  rr_mode,
        input  gnt_ready,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot
    );

    modport master (
        output req,
        output rr_mode,
        output gnt_ready,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot
    );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with runtime fixed-priority / round-robin selection
// and a valid/ready grant register that holds a sticky grant while stalled.
module rr_priority_arbiter #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    rr_priority_arbiter_if.slave  bus
);
    localparam logic [IDXW-1:0] PTR_TOP  = IDXW'(N - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [N-1:0]    OH_ZERO  = {N{1'b0}};
    localparam logic [N-1:0]    OH_ONE   = {{(N-1){1'b0}}, 1'b1};

    logic            r_valid;
    logic [IDXW-1:0] r_idx;
    logic [N-1:0]    r_onehot;
    logic [IDXW-1:0] r_ptr;

    logic            w_accept;
    logic            w_load;
    logic            w_any;
    logic [IDXW-1:0] w_next_ptr;
    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_winner;
    logic [N-1:0]    w_winner_oh;

    // Scan downward from start with wrap-around; first set request wins.
    function automatic logic [IDXW-1:0] f_pick(
        input logic [N-1:0]    req_v,
        input logic [IDXW-1:0] start
    );
        logic            found;
        logic [IDXW-1:0] win;
        logic [IDXW-1:0] cand_idx;
        int              cand;
        found = 1'b0;
        win   = IDX_ZERO;
        for (int k = 0; k < N; k++) begin
            cand = int'(start) - k;
            if (cand < 0) begin
                cand = cand + N;
            end else begin
                cand = cand;
            end
            cand_idx = IDXW'(cand);
            if (!found && req_v[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Handshake decode and pointer advance.
    always_comb begin
        w_accept   = r_valid & bus.gnt_ready;
        w_load     = ~r_valid | bus.gnt_ready;
        w_next_ptr = r_ptr;
        case ({w_accept, bus.rr_mode})
            2'b11: begin
                if (r_idx == IDX_ZERO) begin
                    w_next_ptr = PTR_TOP;
                end else begin
                    w_next_ptr = r_idx - IDXW'(1);
                end
            end
            2'b10:   w_next_ptr = PTR_TOP;
            default: w_next_ptr = r_ptr;
        endcase
    end

    // Winner search starts from the post-accept pointer so a same-edge reload is fair.
    always_comb begin
        w_any = |bus.req;
        if (bus.rr_mode) begin
            w_start = w_next_ptr;
        end else begin
            w_start = PTR_TOP;
        end
        w_winner    = f_pick(bus.req, w_start);
        w_winner_oh = OH_ONE << w_winner;
    end

    // Grant register and pointer; stall keeps everything, including a stale grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_idx    <= IDX_ZERO;
            r_onehot <= OH_ZERO;
            r_ptr    <= PTR_TOP;
        end else begin
            r_ptr <= w_next_ptr;
            if (w_load) begin
                if (w_any) begin
                    r_valid  <= 1'b1;
                    r_idx    <= w_winner;
                    r_onehot <= w_winner_oh;
                end else begin
                    r_valid  <= 1'b0;
                    r_idx    <= IDX_ZERO;
                    r_onehot <= OH_ZERO;
                end
            end else begin
                r_valid  <= r_valid;
                r_idx    <= r_idx;
                r_onehot <= r_onehot;
            end
        end
    end

    assign bus.gnt_valid  = r_valid;
    assign bus.gnt_idx    = r_idx;
    assign bus.gnt_onehot = r_onehot;
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed table-driven bench for rr_priority_arbiter (N=8) plus a sticky-grant sequence.
module tb_rr_priority_arbiter;
    logic clk;
    logic reset;

    rr_priority_arbiter_if #(.N(8)) bus ();

    rr_priority_arbiter #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rst_n;
        logic       mode;
        logic       rdy;
        logic [7:0] req;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] eo;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic y, input logic [7:0] q,
                       input logic v, input logic [2:0] i, input logic [7:0] o);
        vec_t t;
        t = '{rst_n: r, mode: m, rdy: y, req: q, ev: v, ei: i, eo: o};
        vecs.push_back(t);
    endtask

    task automatic step(input vec_t t, input int idx);
        reset         = t.rst_n;
        bus.rr_mode   = t.mode;
        bus.gnt_ready = t.rdy;
        bus.req       = t.req;
        @(posedge clk);
        #1;
        chk("gnt_valid",  idx, 32'(bus.gnt_valid),  32'(t.ev));
        chk("gnt_idx",    idx, 32'(bus.gnt_idx),    32'(t.ei));
        chk("gnt_onehot", idx, 32'(bus.gnt_onehot), 32'(t.eo));
        chk("popcount",   idx, 32'($countones(bus.gnt_onehot)), 32'(t.ev));
    endtask

    initial begin
        vec_t h;
        reset         = 1'b0;
        bus.req       = 8'h00;
        bus.rr_mode   = 1'b0;
        bus.gnt_ready = 1'b1;

        // reset, then release with all requests up
        add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00);
        add(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 3'd7, 8'h80);
        // fixed priority
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b1, 8'h26, 1'b1, 3'd5, 8'h20);
        // idle cycle returns pointer to 7, then round robin sweep
        add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        for (int k = 7; k >= 0; k--) add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 3'(k), 8'h01 << k);
        add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd7, 8'h80);
        // stall holds grant 7 while req changes
        add(1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 8'h01);
        // pointer wrap
        add(1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 3'd0, 8'h01);
        // idle with ready low, then request, then reset mid-stall
        add(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 3'd4, 8'h10);
        add(1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 3'd4, 8'h10);
        add(1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 3'd0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
        // mode switching: fixed accept restores pointer, rr resumes below last grant
        add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 3'd7, 8'h80);
        add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd6, 8'h40);
        add(1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 3'd3, 8'h08);
        add(1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 3'd3, 8'h08);
        add(1'b1, 1'b1, 1'b1, 8'h09, 1'b1, 3'd0, 8'h01);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // sticky grant survives its request dropping to zero, then drains
        h = '{rst_n: 1'b1, mode: 1'b1, rdy: 1'b1, req: 8'h00, ev: 1'b0, ei: 3'd0, eo: 8'h00};
        step(h, 100);
        h = '{rst_n: 1'b1, mode: 1'b1, rdy: 1'b0, req: 8'h20, ev: 1'b1, ei: 3'd5, eo: 8'h20};
        step(h, 101);
        h = '{rst_n: 1'b1, mode: 1'b1, rdy: 1'b0, req: 8'h00, ev: 1'b1, ei: 3'd5, eo: 8'h20};
        step(h, 102);
        step(h, 103);
        h = '{rst_n: 1'b1, mode: 1'b1, rdy: 1'b1, req: 8'h00, ev: 1'b0, ei: 3'd0, eo: 8'h00};
        step(h, 104);
        // pointer is 4 after accepting 5: request 5 and 3 gives 3
        h = '{rst_n: 1'b1, mode: 1'b1, rdy: 1'b1, req: 8'h28, ev: 1'b1, ei: 3'd3, eo: 8'h08};
        step(h, 105);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
